// File: rtl/teller_arbiter.sv
// Round-robin arbitration of N teller requesters onto one shared account-balance
// update datapath, sequenced as grant, execute and report by a 4-state FSM.
module teller_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AMT_W = 16,
    parameter int unsigned BAL_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       op,
    input  logic [N_REQ*AMT_W-1:0] amt,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [BAL_W-1:0]       balance
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               op_q, op_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic               flag_q, flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               arb_found_s;
    logic [PTR_W-1:0]   arb_win_s;
    logic [PTR_W-1:0]   cand_s;
    logic [BAL_W:0]     amt_ext_s;
    logic [BAL_W:0]     bal_ext_s;
    logic [BAL_W:0]     sum_s;
    logic               reject_s;
    logic [BAL_W-1:0]   bal_next_s;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin search: first active request at or above the pointer, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_win_s   = ptr_q;
        cand_s      = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_s = wrap_idx(ptr_q, i);
            if (!arb_found_s && req[cand_s]) begin
                arb_found_s = 1'b1;
                arb_win_s   = cand_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Balance update datapath; overflow is judged one bit wider than the balance.
    always_comb begin
        amt_ext_s  = {{(BAL_W + 1 - AMT_W){1'b0}}, amt_q};
        bal_ext_s  = {1'b0, bal_q};
        sum_s      = bal_ext_s + amt_ext_s;
        reject_s   = 1'b0;
        bal_next_s = bal_q;
        if (op_q) begin
            reject_s   = sum_s[BAL_W];
            bal_next_s = sum_s[BAL_W-1:0];
        end else begin
            reject_s   = (amt_ext_s > bal_ext_s);
            bal_next_s = bal_q - amt_ext_s[BAL_W-1:0];
        end
    end

    // Transaction sequencer; gnt is only rewritten while idle so it stays
    // asserted through the registered done/err pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        amt_d   = amt_q;
        bal_d   = bal_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found_s) begin
                    state_d = S_GRANT;
                    win_d   = arb_win_s;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << arb_win_s;
                    flag_d  = 1'b0;
                end else begin
                    gnt_d   = '0;
                end
            end
            S_GRANT: begin
                op_d    = op[win_q];
                amt_d   = amt[32'(win_q)*AMT_W +: AMT_W];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                flag_d  = reject_s;
                if (!reject_s) begin
                    bal_d = bal_next_s;
                end else begin
                    bal_d = bal_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = flag_q;
                ptr_d   = wrap_idx(win_q, 32'd1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            op_q    <= 1'b0;
            amt_q   <= '0;
            bal_q   <= '0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            bal_q   <= bal_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign balance = bal_q;

endmodule

// File: tb/tb_teller_arbiter.sv
// Directed self-checking bench for teller_arbiter (N_REQ=4, AMT_W=16, BAL_W=16).
module tb_teller_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [63:0] amt;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] balance;

    int checks = 0;
    int errors = 0;

    teller_arbiter #(.N_REQ(4), .AMT_W(16), .BAL_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .op      (op),
        .amt     (amt),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .balance (balance)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1);
    end

    // Drives one transaction from idle; returns grant one cycle later, cycles to done, err and balance.
    task automatic run_txn(input int t, input logic o, input logic [15:0] a,
                           output logic [3:0] g1, output int lat,
                           output logic e, output logic [15:0] bal);
        req[t] = 1'b1;
        op[t]  = o;
        amt[t*16 +: 16] = a;
        @(negedge clk);
        g1  = gnt;
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        e   = err;
        bal = balance;
        req[t] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        checks++; if (gnt !== 4'b0000)     begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (balance !== 16'd0)   begin errors++; $display("FAIL reset_balance: got %0d want 0", balance); end
        req   = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec;
        int seen_done;
        req = 4'b0001; op = 4'b0001; amt[15:0] = 16'd100;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_exec_gnt: got %b want 0001", gnt); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_exec_async: gnt=%b busy=%b want 0000/0", gnt, busy); end
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        checks++; if (seen_done != 0)   begin errors++; $display("FAIL rst_exec_done: got done pulse want none"); end
        checks++; if (balance !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_exec_bal: balance=%0d busy=%b want 0/0", balance, busy); end
    endtask

    task automatic test_single_deposit;
        logic [3:0] g; int lat; logic e; logic [15:0] b;
        run_txn(0, 1'b1, 16'd250, g, lat, e, b);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL dep_gnt: got %b want 0001", g); end
        checks++; if (lat != 3)      begin errors++; $display("FAIL dep_latency: got %0d want 3", lat); end
        checks++; if (e !== 1'b0)    begin errors++; $display("FAIL dep_err: got %b want 0", e); end
        checks++; if (b !== 16'd250) begin errors++; $display("FAIL dep_balance: got %0d want 250", b); end
        checks++; if (done !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL dep_after: done=%b gnt=%b want 0/0000", done, gnt); end
    endtask

    task automatic test_overdraw;
        logic [3:0] g; int lat; logic e; logic [15:0] b;
        run_txn(2, 1'b0, 16'd300, g, lat, e, b);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL ovd_gnt: got %b want 0100", g); end
        checks++; if (lat != 3 || e !== 1'b1) begin errors++; $display("FAIL ovd_err: lat=%0d err=%b want 3/1", lat, e); end
        checks++; if (b !== 16'd250) begin errors++; $display("FAIL ovd_balance: got %0d want 250", b); end
        run_txn(2, 1'b0, 16'd250, g, lat, e, b);
        checks++; if (e !== 1'b0)    begin errors++; $display("FAIL wd_exact_err: got %b want 0", e); end
        checks++; if (b !== 16'd0)   begin errors++; $display("FAIL wd_exact_balance: got %0d want 0", b); end
    endtask

    task automatic test_overflow;
        logic [3:0] g; int lat; logic e; logic [15:0] b;
        run_txn(3, 1'b1, 16'd65000, g, lat, e, b);
        checks++; if (g !== 4'b1000 || b !== 16'd65000) begin errors++; $display("FAIL ovf_setup: gnt=%b bal=%0d want 1000/65000", g, b); end
        run_txn(3, 1'b1, 16'd600, g, lat, e, b);
        checks++; if (e !== 1'b1)      begin errors++; $display("FAIL ovf_err: got %b want 1", e); end
        checks++; if (b !== 16'd65000) begin errors++; $display("FAIL ovf_balance: got %0d want 65000", b); end
        run_txn(3, 1'b1, 16'd535, g, lat, e, b);
        checks++; if (e !== 1'b0 || b !== 16'd65535) begin errors++; $display("FAIL ovf_max: err=%b bal=%0d want 0/65535", e, b); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [5];
        int n;
        int last;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (balance !== 16'd0) begin errors++; $display("FAIL rr_reset_balance: got %0d want 0", balance); end
        req = 4'b1111; op = 4'b1111; amt = {16'd1, 16'd1, 16'd1, 16'd1};
        n = 0; last = -1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (done) begin
                checks++; if (gnt !== exp_g[n]) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", n, gnt, exp_g[n]); end
                if (n == 0) begin
                    checks++; if (c != 3) begin errors++; $display("FAIL rr_first_done: cycle %0d want 3", c); end
                end else begin
                    checks++; if (c - last != 4) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want 4", n, c - last); end
                end
                checks++; if (balance !== 16'(n + 1)) begin errors++; $display("FAIL rr_balance[%0d]: got %0d want %0d", n, balance, n + 1); end
                last = c;
                n++;
            end
        end
        req = 4'b0000;
        checks++; if (n != 5) begin errors++; $display("FAIL rr_timeout: got %0d dones want 5", n); end
        @(negedge clk);
    endtask

    task automatic test_req_withdrawn;
        req[1] = 1'b1; op[1] = 1'b1; amt[31:16] = 16'd10;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wdr_gnt: got %b want 0010", gnt); end
        @(negedge clk);
        req[1] = 1'b0; op[1] = 1'b0; amt[31:16] = 16'd999;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wdr_early_done: got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wdr_done: done=%b err=%b want 1/0", done, err); end
        checks++; if (balance !== 16'd15 || gnt !== 4'b0010) begin errors++; $display("FAIL wdr_balance: bal=%0d gnt=%b want 15/0010", balance, gnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL wdr_idle: done=%b gnt=%b want 0/0000", done, gnt); end
        // Pointer now at 2: tellers 0..2 all request a zero-amount withdrawal.
        req = 4'b0111; op = 4'b0000; amt = 64'd0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ptr_next: got %b want 0100", gnt); end
        req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || err !== 1'b0 || balance !== 16'd15) begin errors++; $display("FAIL zero_amt: done=%b err=%b bal=%0d want 1/0/15", done, err, balance); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        op    = 4'b0000;
        amt   = 64'd0;
        @(negedge clk);
        test_reset;
        test_reset_mid_exec;
        test_single_deposit;
        test_overdraw;
        test_overflow;
        test_round_robin;
        test_req_withdrawn;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
